// File: rtl/lms_pkg.sv
// lms_pkg
//   Shared definitions for the LMS noise-canceller front-end scheduler.
//   - Default microphone sample width and the width of a stored (main, sub) pair.
//   - Scheduler state encoding, kept as plain localparam constants so that
//     older code that compares raw state codes keeps working.
package lms_pkg;

  localparam int DATASIZE_DEF = 24;
  localparam int PAIR_W_DEF   = 2 * DATASIZE_DEF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_BUSY  = 2'd3;

endpackage

// File: rtl/lms_pair_fifo.sv
// lms_pair_fifo
//   Small show-ahead FIFO holding (main, sub) sample pairs for the scheduler.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     push, wdata  write request and pair; ignored when full unless popping
//     pop          read request; head advances, ignored when empty
//     flush        synchronous clear, wins over push and pop
//     rdata        current head pair (valid when !empty)
//     full, empty  occupancy flags
//     level        current occupancy, 0..DEPTH
module lms_pair_fifo
  import lms_pkg::*;
#(
  parameter int WIDTH = PAIR_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle, so the slot freed by the pop is reused immediately.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign level = count;
  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/lms_sample_scheduler.sv
// lms_sample_scheduler
//   Front-end scheduler for the two-microphone LMS noise canceller. Buffers
//   incoming (main, sub) pairs and hands them one at a time to the LMS
//   sequencing controller, with overrun detection and a hang watchdog.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     enable                run request (level)
//     in_valid/in_main/in_sub  ADC sample pair, cannot be stalled
//     in_ready              FIFO not full (informational)
//     core_start            1-cycle pulse when leaving IDLE
//     start_sample          1-cycle pulse, main_out/sub_out valid
//     main_out/sub_out      pair being processed, held until next pop
//     core_done             controller write_output completion pulse
//     busy                  iteration in progress (ISSUE or BUSY)
//     fifo_level            FIFO occupancy
//     overrun_flag/cnt      sticky drop flag and saturating drop count
//     timeout_err           sticky watchdog abort flag
//     clr_status            synchronous clear of the status registers
module lms_sample_scheduler
  import lms_pkg::*;
#(
  parameter int DATASIZE       = DATASIZE_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          in_valid,
  input  logic [DATASIZE-1:0]           in_main,
  input  logic [DATASIZE-1:0]           in_sub,
  output logic                          in_ready,
  output logic                          core_start,
  output logic                          start_sample,
  output logic [DATASIZE-1:0]           main_out,
  output logic [DATASIZE-1:0]           sub_out,
  input  logic                          core_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun_flag,
  output logic [CNT_W-1:0]              overrun_cnt,
  output logic                          timeout_err,
  input  logic                          clr_status
);

  localparam int PAIR_W = 2 * DATASIZE;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES);
  // The watchdog is cleared in ISSUE and counts BUSY cycles; the abort fires
  // on the edge at which the count would reach TIMEOUT_CYCLES-1.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

  logic [1:0]        state;
  logic [WD_W-1:0]   wd_cnt;
  logic [PAIR_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              wd_expire;
  logic              iter_end;
  logic              drop;

  // core_done has priority over a coinciding watchdog expiry.
  assign wd_expire  = (state == ST_BUSY) && !core_done && (wd_cnt == WD_LAST);
  assign iter_end   = (state == ST_BUSY) && (core_done || wd_expire);
  assign fifo_pop   = (state == ST_WAIT) && enable && !fifo_empty;
  assign fifo_flush = ((state == ST_WAIT) && !enable) || (iter_end && !enable);
  assign fifo_push  = in_valid && (state != ST_IDLE);
  assign drop       = fifo_push && fifo_full && !fifo_pop;

  assign in_ready = !fifo_full;
  assign busy     = (state == ST_ISSUE) || (state == ST_BUSY);

  lms_pair_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata ({in_main, in_sub}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // The start pulses are registered on the transition into WAIT/ISSUE so they
  // line up with the cycle the new state is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wd_cnt       <= '0;
      core_start   <= 1'b0;
      start_sample <= 1'b0;
      main_out     <= '0;
      sub_out      <= '0;
    end else begin
      core_start   <= 1'b0;
      start_sample <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state      <= ST_WAIT;
            core_start <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (!fifo_empty) begin
            state               <= ST_ISSUE;
            start_sample        <= 1'b1;
            {main_out, sub_out} <= head;
          end
        end
        ST_ISSUE: begin
          wd_cnt <= '0;
          state  <= ST_BUSY;
        end
        ST_BUSY: begin
          if (iter_end) state  <= enable ? ST_WAIT : ST_IDLE;
          else          wd_cnt <= wd_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A new event in the same cycle as clr_status wins, so nothing is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_flag <= 1'b0;
      overrun_cnt  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (drop) begin
        overrun_flag <= 1'b1;
        if (clr_status)              overrun_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        else if (overrun_cnt != '1)  overrun_cnt <= overrun_cnt + 1'b1;
      end else if (clr_status) begin
        overrun_flag <= 1'b0;
        overrun_cnt  <= '0;
      end
      if (wd_expire)       timeout_err <= 1'b1;
      else if (clr_status) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lms_sample_scheduler.sv
// tb_lms_sample_scheduler
//   Self-checking bench for lms_sample_scheduler. A transaction-level model
//   (phase + queue of pairs + iteration age) predicts every output after each
//   clock; directed scenarios are followed by a randomized run.
module tb_lms_sample_scheduler;

  localparam int DATASIZE       = 24;
  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_W          = 4;
  localparam int CNT_MAX        = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic                in_valid;
  logic [23:0]         in_main;
  logic [23:0]         in_sub;
  logic                in_ready;
  logic                core_start;
  logic                start_sample;
  logic [23:0]         main_out;
  logic [23:0]         sub_out;
  logic                core_done;
  logic                busy;
  logic [2:0]          fifo_level;
  logic                overrun_flag;
  logic [CNT_W-1:0]    overrun_cnt;
  logic                timeout_err;
  logic                clr_status;

  int checks = 0;
  int errors = 0;

  lms_sample_scheduler #(
    .DATASIZE       (DATASIZE),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_main      (in_main),
    .in_sub       (in_sub),
    .in_ready     (in_ready),
    .core_start   (core_start),
    .start_sample (start_sample),
    .main_out     (main_out),
    .sub_out      (sub_out),
    .core_done    (core_done),
    .busy         (busy),
    .fifo_level   (fifo_level),
    .overrun_flag (overrun_flag),
    .overrun_cnt  (overrun_cnt),
    .timeout_err  (timeout_err),
    .clr_status   (clr_status)
  );

  always #5 clk = ~clk;

  // Reference model: what the scheduler is doing, in plain terms.
  typedef enum {M_OFF, M_READY, M_START, M_RUN} mphase_t;
  mphase_t     ph;
  logic [47:0] q[$];
  int          age;
  bit          e_core_start;
  bit          e_start_sample;
  logic [23:0] e_main;
  logic [23:0] e_sub;
  bit          e_flag;
  int          e_cnt;
  bit          e_terr;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    ph = M_OFF;
    q.delete();
    age = 0;
    e_core_start = 1'b0;
    e_start_sample = 1'b0;
    e_main = '0;
    e_sub = '0;
    e_flag = 1'b0;
    e_cnt = 0;
    e_terr = 1'b0;
  endtask

  // Predicts the state after the next rising edge given this cycle's inputs.
  task automatic modelStep(input bit en, input bit iv, input logic [47:0] pair,
                           input bit done, input bit clr);
    bit popping, expired, ending, drop, flush;
    popping = (ph == M_READY) && en && (q.size() > 0);
    expired = (ph == M_RUN) && !done && (age + 1 == TIMEOUT_CYCLES);
    ending  = (ph == M_RUN) && (done || expired);
    drop    = 1'b0;
    e_core_start   = (ph == M_OFF) && en;
    e_start_sample = popping;
    if (popping) {e_main, e_sub} = q.pop_front();
    if (ph != M_OFF && iv) begin
      if (q.size() < FIFO_DEPTH) q.push_back(pair);
      else drop = 1'b1;
    end
    flush = ((ph == M_READY) && !en) || (ending && !en);
    if (flush) q.delete();
    if (drop) begin
      e_flag = 1'b1;
      if (clr) e_cnt = 1;
      else if (e_cnt < CNT_MAX) e_cnt = e_cnt + 1;
    end else if (clr) begin
      e_flag = 1'b0;
      e_cnt = 0;
    end
    if (expired) e_terr = 1'b1;
    else if (clr) e_terr = 1'b0;
    age = age + 1;
    case (ph)
      M_OFF:   if (en) ph = M_READY;
      M_READY: if (!en) ph = M_OFF;
               else if (popping) begin ph = M_START; age = 0; end
      M_START: ph = M_RUN;
      M_RUN:   if (ending) ph = en ? M_READY : M_OFF;
      default: ph = M_OFF;
    endcase
  endtask

  task automatic compareAll();
    checkOutput("core_start",   64'(core_start),   64'(e_core_start));
    checkOutput("start_sample", 64'(start_sample), 64'(e_start_sample));
    checkOutput("main_out",     64'(main_out),     64'(e_main));
    checkOutput("sub_out",      64'(sub_out),      64'(e_sub));
    checkOutput("busy",         64'(busy),         64'(ph == M_START || ph == M_RUN));
    checkOutput("fifo_level",   64'(fifo_level),   64'(q.size()));
    checkOutput("in_ready",     64'(in_ready),     64'(q.size() < FIFO_DEPTH));
    checkOutput("overrun_flag", 64'(overrun_flag), 64'(e_flag));
    checkOutput("overrun_cnt",  64'(overrun_cnt),  64'(e_cnt));
    checkOutput("timeout_err",  64'(timeout_err),  64'(e_terr));
  endtask

  task automatic applyStimulus(input bit en, input bit iv, input logic [23:0] m,
                               input logic [23:0] s, input bit done, input bit clr);
    enable = en;
    in_valid = iv;
    in_main = m;
    in_sub = s;
    core_done = done;
    clr_status = clr;
    modelStep(en, iv, {m, s}, done, clr);
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic idleCycle(input bit en);
    applyStimulus(en, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic clearInputs();
    enable = 1'b0;
    in_valid = 1'b0;
    in_main = '0;
    in_sub = '0;
    core_done = 1'b0;
    clr_status = 1'b0;
  endtask

  logic [23:0] t3_main [7];
  bit          cur_en;
  bit          slow;
  bit          iv_r;
  bit          done_r;
  bit          clr_r;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout observed=running required=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    clearInputs();
    modelReset();
    #1;
    compareAll();
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // 1: enable -> core_start, first pair issued two clocks after arrival
    idleCycle(1'b0);
    idleCycle(1'b1);
    checkOutput("t1_core_start", 64'(core_start), 64'd1);
    idleCycle(1'b1);
    checkOutput("t1_core_start_once", 64'(core_start), 64'd0);
    applyStimulus(1'b1, 1'b1, 24'h000123, 24'hFFFF00, 1'b0, 1'b0);
    checkOutput("t1_not_yet", 64'(start_sample), 64'd0);
    idleCycle(1'b1);
    checkOutput("t1_start_sample", 64'(start_sample), 64'd1);
    checkOutput("t1_main", 64'(main_out), 64'h000123);
    checkOutput("t1_sub", 64'(sub_out), 64'hFFFF00);
    checkOutput("t1_busy", 64'(busy), 64'd1);

    // 2: next pair queued during BUSY, issued one clock after returning to WAIT
    applyStimulus(1'b1, 1'b1, 24'h0ABCDE, 24'h123456, 1'b0, 1'b0);
    repeat (8) idleCycle(1'b1);
    applyStimulus(1'b1, 1'b0, 24'h0, 24'h0, 1'b1, 1'b0);
    checkOutput("t2_wait", 64'(busy), 64'd0);
    idleCycle(1'b1);
    checkOutput("t2_start_sample", 64'(start_sample), 64'd1);
    checkOutput("t2_main", 64'(main_out), 64'h0ABCDE);

    // 3: six pushes into depth-4 FIFO during an iteration
    for (int i = 0; i < 7; i++) t3_main[i] = 24'h300000 + 24'(i);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 1'b1, t3_main[i], ~t3_main[i], 1'b0, 1'b0);
    checkOutput("t3_level", 64'(fifo_level), 64'd4);
    checkOutput("t3_cnt", 64'(overrun_cnt), 64'd2);
    checkOutput("t3_flag", 64'(overrun_flag), 64'd1);
    applyStimulus(1'b1, 1'b0, 24'h0, 24'h0, 1'b0, 1'b1);
    checkOutput("t3_clr_cnt", 64'(overrun_cnt), 64'd0);
    checkOutput("t3_clr_flag", 64'(overrun_flag), 64'd0);
    applyStimulus(1'b1, 1'b1, t3_main[6], ~t3_main[6], 1'b0, 1'b1);
    checkOutput("t3_clr_drop_cnt", 64'(overrun_cnt), 64'd1);
    checkOutput("t3_clr_drop_flag", 64'(overrun_flag), 64'd1);
    applyStimulus(1'b1, 1'b0, 24'h0, 24'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idleCycle(1'b1);
      checkOutput("t3_order", 64'(main_out), 64'(t3_main[i]));
      idleCycle(1'b1);
      applyStimulus(1'b1, 1'b0, 24'h0, 24'h0, 1'b1, 1'b0);
    end

    // 4: watchdog abort 16 clocks after ISSUE, then done on that same cycle
    applyStimulus(1'b1, 1'b1, 24'h444444, 24'h000044, 1'b0, 1'b1);
    idleCycle(1'b1);
    checkOutput("t4_start", 64'(start_sample), 64'd1);
    for (int k = 1; k <= 16; k++) begin
      idleCycle(1'b1);
      if (k == 15) checkOutput("t4_terr_early", 64'(timeout_err), 64'd0);
    end
    checkOutput("t4_terr", 64'(timeout_err), 64'd1);
    checkOutput("t4_back_to_wait", 64'(busy), 64'd0);
    applyStimulus(1'b1, 1'b1, 24'h454545, 24'h000045, 1'b0, 1'b1);
    checkOutput("t4_terr_clr", 64'(timeout_err), 64'd0);
    idleCycle(1'b1);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b1, 1'b0, 24'h0, 24'h0, (k == 16), 1'b0);
      if (k == 15) checkOutput("t4_busy_late", 64'(busy), 64'd1);
    end
    checkOutput("t4_done_wins", 64'(timeout_err), 64'd0);
    checkOutput("t4_done_exit", 64'(busy), 64'd0);

    // 5: enable dropped mid-iteration waits for completion, then flushes
    applyStimulus(1'b1, 1'b1, 24'h555001, 24'h000501, 1'b0, 1'b0);
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 24'h555002, 24'h000502, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 24'h555003, 24'h000503, 1'b0, 1'b0);
    repeat (3) idleCycle(1'b0);
    checkOutput("t5_still_busy", 64'(busy), 64'd1);
    applyStimulus(1'b0, 1'b0, 24'h0, 24'h0, 1'b1, 1'b0);
    checkOutput("t5_idle", 64'(busy), 64'd0);
    checkOutput("t5_flushed", 64'(fifo_level), 64'd0);
    idleCycle(1'b0);

    // 6: asynchronous reset in the middle of an iteration, then restart
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 24'h666001, 24'h000601, 1'b0, 1'b0);
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 24'h666002, 24'h000602, 1'b0, 1'b0);
    repeat (2) idleCycle(1'b1);
    #3;
    rst_n = 1'b0;
    clearInputs();
    #1;
    modelReset();
    compareAll();
    checkOutput("t6_rst_busy", 64'(busy), 64'd0);
    checkOutput("t6_rst_main", 64'(main_out), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    compareAll();
    rst_n = 1'b1;
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 24'h666003, 24'h000603, 1'b0, 1'b0);
    idleCycle(1'b1);
    checkOutput("t6_restart_main", 64'(main_out), 64'h666003);
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b0, 24'h0, 24'h0, 1'b1, 1'b0);

    // Randomized run against the model
    cur_en = 1'b1;
    slow = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 49) == 0) cur_en = !cur_en;
      if (c % 100 == 50) slow = !slow;
      iv_r   = ($urandom_range(0, 99) < 40);
      done_r = slow ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 5) == 0);
      clr_r  = ($urandom_range(0, 29) == 0);
      applyStimulus(cur_en, iv_r, 24'($urandom), 24'($urandom), done_r, clr_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
